counter_updown_rpt: RTL and testbench
=====================================

# counter_updown_rpt

Parametrised up/down counter with a programmable terminal value, wrap or saturate mode, cascade carry/borrow pulses and built-in press-and-hold auto-repeat. It drives cursor column and row positions in the editor datapath. Level-held `inc`/`dec` requests come straight from the key decoder, and `carry`/`borrow` chain a column instance into a row instance.

## Interface
- `WIDTH`, default 6: counter width in bits.
- `SATURATE`, default 0: 0 means wrap at the bounds; 1 means clamp at 0 and `limit`.
- `DLY`, default 8: cycles from the first step to the first repeat step. 0 disables auto-repeat, giving one step per press.
- `RATE`, default 2: cycles between repeat steps. Must be at least 1.
- `CLK` input, 1 bit: single clock, rising edge.
- `CLR_N` input, 1 bit: asynchronous, active-low reset.
- `clr` input, 1 bit: synchronous clear.
- `parallel` input, 1 bit: synchronous load of `load`.
- `load` input, WIDTH bits: load value.
- `limit` input, WIDTH bits: terminal value. The count range is 0..`limit`.
- `inc` input, 1 bit: level-held count-up request.
- `dec` input, 1 bit: level-held count-down request.
- `Q_OUT` output, WIDTH bits: count value.
- `at_zero` output, 1 bit: high when `Q_OUT`==0. Combinational.
- `at_max` output, 1 bit: high when `Q_OUT`>=`limit`. Combinational.
- `carry` output, 1 bit: 1-cycle registered pulse on an up-wrap.
- `borrow` output, 1 bit: 1-cycle registered pulse on a down-wrap.

## Operation
- Reset (`CLR_N`=0) gives: `Q_OUT`=0, `carry`=0, `borrow`=0, FSM in IDLE, repeat timer 0. Consequently `at_zero`=1, and `at_max`=1 only if `limit`==0.
- Per-cycle priority: `clr` > `parallel` > step.
  - `clr`: `Q_OUT`<=0.
  - `parallel`: `Q_OUT`<=min(`load`,`limit`).
  - Either of these forces the FSM to IDLE and suppresses `carry`/`borrow`.
- A "step" is one ±1 operation, issued by the repeat FSM.
- Up step:
  - If `Q_OUT`<`limit`: Q+1.
  - Otherwise, wrap mode: `Q_OUT`<=0 and `carry`=1 next cycle.
  - Otherwise, saturate mode: `Q_OUT`<=`limit`, no pulse.
- Down step:
  - If `Q_OUT`==0, wrap mode: `Q_OUT`<=`limit` and `borrow`=1.
  - If `Q_OUT`==0, saturate mode: hold 0.
  - If `Q_OUT`>`limit` (because `limit` was lowered): `Q_OUT`<=`limit`, no pulse.
  - Otherwise: Q-1.
- A `limit` change has no effect until the next step or load. Arithmetic stays within WIDTH bits; no overflow is possible.
- Repeat FSM states:
  - IDLE: `inc` xor `dec` high issues a step in that direction and moves to HOLD. The timer is loaded with DLY-1. If DLY=0, the FSM goes to LATCHED instead.
  - HOLD: the same request still high decrements the timer. When the timer reaches 0, a step is issued, the timer is loaded with RATE-1 and the FSM moves to REPEAT.
  - REPEAT: the same request still high decrements the timer. When the timer reaches 0, a step is issued and the timer is reloaded with RATE-1.
  - LATCHED: stay, with no steps, while the same request is held.
  - In HOLD, REPEAT and LATCHED, any of the following returns the FSM to IDLE with no step in that cycle: request dropped, both `inc` and `dec` high, or direction reversed.
    - A reversal is therefore seen as a fresh press one cycle later.
    - `inc`&`dec` both high in IDLE: no step.

## Timing
- `Q_OUT` updates on the rising edge after the cycle in which a step, `clr` or `parallel` is sampled.
- `carry`/`borrow` assert in the same cycle as the wrapped `Q_OUT` value and last exactly one cycle.
- With `inc` first sampled high in cycle 0 and held, steps occur in cycles 0, DLY, DLY+RATE, DLY+2·RATE, …
- Cascade: a column `carry` drives the row `inc` for one cycle. That row sees a fresh press and moves exactly one step, provided DLY≥2.
- `CLR_N` assertion mid-repeat clears immediately and asynchronously. Deassertion must be synchronised by the top level.
- A `clr`/`parallel` while a key is held: the still-held request steps again one cycle after the load, as a fresh press.

## Structure
- Shared package `counter_pkg`:
  - repeat FSM state enum {IDLE, HOLD, REPEAT, LATCHED};
  - direction encoding;
  - function for the timer width, max(1,$clog2(max(DLY,RATE))).
- Sub-module `repeat_ctrl`: owns the FSM and timer. Inputs: `inc`, `dec`, abort. Outputs: `step_up`, `step_dn`. The top module holds the count register, bound logic and pulses.

## Test plan
All scenarios use WIDTH=6, `limit`=39.
- Reset: drive `CLR_N` low mid-count -> `Q_OUT`=0, `at_zero`=1, `carry`=0 immediately.
- Wrap up, SATURATE=0: load 38, then 2-cycle `inc` pulses -> 39, then 0. `carry` is high only in the cycle `Q_OUT`=0. `at_max` is high at 39.
- Saturate, SATURATE=1: `dec` pulse at 0 -> 0, no `borrow`. Load 50 -> `Q_OUT`=39 (clamped).
- Auto-repeat, DLY=8, RATE=2: hold `inc` for 14 cycles from 0 -> steps in cycles 0, 8, 10, 12. Final `Q_OUT`=4.
- Conflicts:
  - `inc`+`dec` both high -> no change.
  - `clr` with `inc` held -> 0, then 1 on the following cycle.
  - `parallel`+`inc` -> `load` wins.
- Limit lowered: `Q_OUT`=30, `limit` set to 10, `dec` pulse -> `Q_OUT`=10 with no `borrow`.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the cursor up/down counter: repeat FSM states, step direction
// and the repeat-timer width helper.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LATCHED
    } rpt_state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // The timer only ever holds DLY-1 or RATE-1, so clog2 of the larger one suffices.
    function automatic int timer_w(input int dly, input int rate);
        int m;
        int w;
        m = (dly > rate) ? dly : rate;
        w = $clog2(m);
        return (w > 1) ? w : 1;
    endfunction

endpackage

// File: rtl/counter_updown_rpt_repeat_ctrl.sv
// Press-and-hold auto-repeat: turns level-held inc/dec requests into single-cycle
// step pulses (first step at once, then after DLY cycles, then every RATE cycles).
module repeat_ctrl
    import counter_pkg::*;
#(
    parameter int DLY  = 8,
    parameter int RATE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic abort,
    output logic step_up,
    output logic step_dn
);

    localparam int TW = timer_w(DLY, RATE);
    localparam logic [TW-1:0] DLY_LD  = TW'((DLY > 0) ? DLY - 1 : 0);
    localparam logic [TW-1:0] RATE_LD = TW'(RATE - 1);

    rpt_state_t    state, state_nxt;
    dir_t          dir, dir_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          step;
    logic          req_up, req_dn, req_any, same;

    assign req_up  = inc & ~dec;
    assign req_dn  = dec & ~inc;
    assign req_any = req_up | req_dn;
    assign same    = (dir == DIR_UP) ? req_up : req_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dir   <= DIR_UP;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        tmr_nxt   = tmr;
        step      = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        step    = 1'b1;
                        dir_nxt = req_up ? DIR_UP : DIR_DN;
                        if (DLY == 0) begin
                            state_nxt = LATCHED;
                        end else begin
                            state_nxt = HOLD;
                            tmr_nxt   = DLY_LD;
                        end
                    end
                end
                HOLD, REPEAT: begin
                    // Dropped, doubled or reversed request aborts; a reversal re-enters as a fresh press.
                    if (!same) begin
                        state_nxt = IDLE;
                        tmr_nxt   = '0;
                    end else if (tmr == '0) begin
                        step      = 1'b1;
                        tmr_nxt   = RATE_LD;
                        state_nxt = REPEAT;
                    end else begin
                        tmr_nxt = tmr - 1'b1;
                    end
                end
                LATCHED: begin
                    if (!same) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // dir_nxt equals dir outside IDLE, so it names the direction of any step.
    assign step_up = step & (dir_nxt == DIR_UP);
    assign step_dn = step & (dir_nxt == DIR_DN);

endmodule

// File: rtl/counter_updown_rpt.sv
// Cursor position counter: range 0..limit, wrap or saturate at the bounds, registered
// carry/borrow pulses for cascading, and built-in key auto-repeat.
module counter_updown_rpt
    import counter_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int SATURATE = 0,
    parameter int DLY      = 8,
    parameter int RATE     = 2
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             clr,
    input  logic             parallel,
    input  logic [WIDTH-1:0] load,
    input  logic [WIDTH-1:0] limit,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] Q_OUT,
    output logic             at_zero,
    output logic             at_max,
    output logic             carry,
    output logic             borrow
);

    logic             step_up, step_dn, abort;
    logic [WIDTH-1:0] q_nxt;
    logic             carry_nxt, borrow_nxt;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign abort = clr | parallel;

    repeat_ctrl #(
        .DLY (DLY),
        .RATE(RATE)
    ) u_repeat_ctrl (
        .clk    (CLK),
        .rst_n  (CLR_N),
        .inc    (inc),
        .dec    (dec),
        .abort  (abort),
        .step_up(step_up),
        .step_dn(step_dn)
    );

    always_comb begin
        q_nxt      = Q_OUT;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (parallel) begin
            q_nxt = clamp(load, limit);
        end else if (step_up) begin
            if (Q_OUT < limit) begin
                q_nxt = Q_OUT + 1'b1;
            end else if (SATURATE != 0) begin
                q_nxt = limit;
            end else begin
                q_nxt     = '0;
                carry_nxt = 1'b1;
            end
        end else if (step_dn) begin
            if (Q_OUT == '0) begin
                if (SATURATE == 0) begin
                    q_nxt      = limit;
                    borrow_nxt = 1'b1;
                end
            end else if (Q_OUT > limit) begin
                // limit was lowered under the count: snap down without a pulse
                q_nxt = limit;
            end else begin
                q_nxt = Q_OUT - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            Q_OUT  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            Q_OUT  <= q_nxt;
            carry  <= carry_nxt;
            borrow <= borrow_nxt;
        end
    end

    assign at_zero = (Q_OUT == '0);
    assign at_max  = (Q_OUT >= limit);

endmodule

// File: tb/tb_counter_updown_rpt.sv
// Scoreboard bench: four counter configurations share one stimulus stream and are
// checked each cycle against a press-age reference model.
`timescale 1ns/1ps
module tb_counter_updown_rpt;

    localparam int N = 4;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       clr = 1'b0, parallel = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [5:0] load = '0, limit = 6'd39;

    logic [5:0] q_o [N];
    logic       az [N], am [N], cy [N], bw [N];

    always #5 CLK = ~CLK;

    counter_updown_rpt #(.WIDTH(6), .SATURATE(0), .DLY(8), .RATE(2)) dut0 (
        .CLK(CLK), .CLR_N(CLR_N), .clr(clr), .parallel(parallel), .load(load), .limit(limit),
        .inc(inc), .dec(dec), .Q_OUT(q_o[0]), .at_zero(az[0]), .at_max(am[0]),
        .carry(cy[0]), .borrow(bw[0]));
    counter_updown_rpt #(.WIDTH(6), .SATURATE(1), .DLY(8), .RATE(2)) dut1 (
        .CLK(CLK), .CLR_N(CLR_N), .clr(clr), .parallel(parallel), .load(load), .limit(limit),
        .inc(inc), .dec(dec), .Q_OUT(q_o[1]), .at_zero(az[1]), .at_max(am[1]),
        .carry(cy[1]), .borrow(bw[1]));
    counter_updown_rpt #(.WIDTH(6), .SATURATE(0), .DLY(0), .RATE(1)) dut2 (
        .CLK(CLK), .CLR_N(CLR_N), .clr(clr), .parallel(parallel), .load(load), .limit(limit),
        .inc(inc), .dec(dec), .Q_OUT(q_o[2]), .at_zero(az[2]), .at_max(am[2]),
        .carry(cy[2]), .borrow(bw[2]));
    counter_updown_rpt #(.WIDTH(6), .SATURATE(1), .DLY(3), .RATE(3)) dut3 (
        .CLK(CLK), .CLR_N(CLR_N), .clr(clr), .parallel(parallel), .load(load), .limit(limit),
        .inc(inc), .dec(dec), .Q_OUT(q_o[3]), .at_zero(az[3]), .at_max(am[3]),
        .carry(cy[3]), .borrow(bw[3]));

    function automatic int p_sat(input int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction
    function automatic int p_dly(input int k);
        case (k)
            0, 1: return 8;
            2: return 0;
            default: return 3;
        endcase
    endfunction
    function automatic int p_rate(input int k);
        case (k)
            0, 1: return 2;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    typedef struct packed {
        logic [5:0] q;
        logic       c;
        logic       b;
        logic       z;
        logic       m;
    } exp_t;

    exp_t sb[$];

    // Reference state: count, pending pulses, held direction (0 none, 1 up, 2 down), press age.
    int m_q [N], m_c [N], m_b [N], m_prev [N], m_age [N];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    bit done = 1'b0;

    task automatic model_reset(input int k);
        m_q[k] = 0; m_c[k] = 0; m_b[k] = 0; m_prev[k] = 0; m_age[k] = 0;
    endtask

    task automatic model_cycle(input int k);
        int lim, req, sdir;
        exp_t e;
        lim = int'(limit);
        if (!CLR_N) model_reset(k);
        e.q = 6'(m_q[k]);
        e.c = (m_c[k] != 0);
        e.b = (m_b[k] != 0);
        e.z = (m_q[k] == 0);
        e.m = (m_q[k] >= lim);
        sb.push_back(e);
        if (!CLR_N) return;
        req  = (inc && !dec) ? 1 : ((dec && !inc) ? 2 : 0);
        sdir = 0;
        m_c[k] = 0;
        m_b[k] = 0;
        if (clr || parallel) begin
            m_prev[k] = 0;
            m_q[k] = clr ? 0 : ((int'(load) > lim) ? lim : int'(load));
            return;
        end
        if (m_prev[k] == 0) begin
            if (req != 0) begin
                sdir = req; m_prev[k] = req; m_age[k] = 0;
            end
        end else if (req == m_prev[k]) begin
            m_age[k]++;
            if (p_dly(k) > 0 && m_age[k] >= p_dly(k) && ((m_age[k] - p_dly(k)) % p_rate(k)) == 0)
                sdir = req;
        end else begin
            m_prev[k] = 0;
        end
        if (sdir == 1) begin
            if (m_q[k] < lim) m_q[k]++;
            else if (p_sat(k) != 0) m_q[k] = lim;
            else begin m_q[k] = 0; m_c[k] = 1; end
        end else if (sdir == 2) begin
            if (m_q[k] == 0) begin
                if (p_sat(k) == 0) begin m_q[k] = lim; m_b[k] = 1; end
            end else if (m_q[k] > lim) m_q[k] = lim;
            else m_q[k]--;
        end
    endtask

    task automatic cyc(input logic i, input logic d, input logic c, input logic p,
                       input logic [5:0] ld, input logic [5:0] lim, input logic rn);
        @(posedge CLK);
        #1;
        inc = i; dec = d; clr = c; parallel = p; load = ld; limit = lim; CLR_N = rn;
        for (int k = 0; k < N; k++) model_cycle(k);
    endtask

    task automatic chk(input string name, input int k, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d got %0d expected %0d", name, k, cyc_n, got, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge CLK);
            cyc_n++;
            if (sb.size() >= N) begin
                for (int k = 0; k < N; k++) begin
                    e = sb.pop_front();
                    chk("q_out",   k, int'(q_o[k]), int'(e.q));
                    chk("carry",   k, int'(cy[k]),  int'(e.c));
                    chk("borrow",  k, int'(bw[k]),  int'(e.b));
                    chk("at_zero", k, int'(az[k]),  int'(e.z));
                    chk("at_max",  k, int'(am[k]),  int'(e.m));
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog time limit reached got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [5:0] lim_cur;
        int r, len, dsel;
        for (int k = 0; k < N; k++) model_reset(k);
        lim_cur = 6'd39;

        cyc(0, 0, 0, 0, 0, 39, 0);
        cyc(0, 0, 0, 0, 0, 39, 0);
        // wrap up from 38
        cyc(0, 0, 0, 1, 38, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        repeat (2) begin
            cyc(1, 0, 0, 0, 0, 39, 1);
            cyc(1, 0, 0, 0, 0, 39, 1);
            cyc(0, 0, 0, 0, 0, 39, 1);
            cyc(0, 0, 0, 0, 0, 39, 1);
        end
        // down at zero, then clamped load
        cyc(0, 0, 1, 0, 0, 39, 1);
        cyc(0, 1, 0, 0, 0, 39, 1);
        cyc(0, 1, 0, 0, 0, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        cyc(0, 0, 0, 1, 50, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        // 14-cycle hold from 0
        cyc(0, 0, 1, 0, 0, 39, 1);
        repeat (14) cyc(1, 0, 0, 0, 0, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        // both requests high
        repeat (3) cyc(1, 1, 0, 0, 0, 39, 1);
        // clr with inc held
        repeat (3) cyc(1, 0, 0, 0, 0, 39, 1);
        cyc(1, 0, 1, 0, 0, 39, 1);
        repeat (2) cyc(1, 0, 0, 0, 0, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        // parallel with inc
        cyc(1, 0, 0, 1, 20, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        // limit lowered under the count
        cyc(0, 0, 0, 1, 30, 39, 1);
        cyc(0, 1, 0, 0, 0, 10, 1);
        cyc(0, 0, 0, 0, 0, 10, 1);
        cyc(0, 0, 0, 0, 0, 39, 1);
        // reversal mid-hold
        repeat (5) cyc(1, 0, 0, 0, 0, 39, 1);
        repeat (4) cyc(0, 1, 0, 0, 0, 39, 1);
        // async reset mid-repeat
        repeat (12) cyc(1, 0, 0, 0, 0, 39, 1);
        cyc(1, 0, 0, 0, 0, 39, 0);
        cyc(0, 0, 0, 0, 0, 39, 1);

        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                cyc(1'($urandom_range(0, 1)), 1'b0, 1, 0, 0, lim_cur, 1);
            end else if (r < 16) begin
                cyc(1'($urandom_range(0, 1)), 1'b0, 0, 1, 6'($urandom_range(0, 63)), lim_cur, 1);
            end else if (r < 19) begin
                cyc(0, 0, 0, 0, 0, lim_cur, 0);
            end else if (r < 27) begin
                lim_cur = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                      : 6'($urandom_range(0, 12));
                cyc(0, 0, 0, 0, 0, lim_cur, 1);
            end else begin
                dsel = int'($urandom_range(0, 9));
                len  = int'($urandom_range(1, 20));
                repeat (len)
                    cyc(dsel < 5 || dsel == 9, dsel >= 5, 0, 0, 0, lim_cur, 1);
                repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0, 0, lim_cur, 1);
            end
        end

        cyc(0, 0, 0, 0, 0, lim_cur, 1);
        repeat (2) @(posedge CLK);
        done = 1'b1;
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
